// File: rtl/rijndael_keyexpansion_ctrl.sv
// Rijndael key expansion controller.
//
// Expands an NK-word cipher key into NR+1 128-bit round keys and streams them out in
// order over a valid/ready interface. Each schedule step produces NK new words; the
// steps are repacked into 4-word round keys through a small word FIFO (capacity NK+3).
// Only one expansion is in flight at a time.
//
// Ports:
//   clk_i        clock
//   rst_ni       asynchronous active-low reset
//   key_i        cipher key, word 0 in [31:0], byte 0 of each word in [31:24]
//   key_valid_i  key offered
//   key_ready_o  key accepted when key_valid_i && key_ready_o (only while idle)
//   rk_o         round key, oldest word in [31:0]
//   rk_idx_o     index of the round key on rk_o (0..NR)
//   rk_last_o    rk_idx_o == NR
//   rk_valid_o   round key valid
//   rk_ready_i   consumer ready
module rijndael_keyexpansion_ctrl #(
  parameter int unsigned NK = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [32*NK-1:0]  key_i,
  input  logic              key_valid_i,
  output logic              key_ready_o,
  output logic [127:0]      rk_o,
  output logic [3:0]        rk_idx_o,
  output logic              rk_last_o,
  output logic              rk_valid_o,
  input  logic              rk_ready_i
);

  localparam int unsigned NR     = NK + 6;
  localparam int unsigned NSTEPS = (4 * (NR + 1) - NK + NK - 1) / NK;
  localparam int unsigned CAP    = NK + 3;

  if (!(NK == 4 || NK == 6 || NK == 8)) begin : g_bad_nk
    $error("rijndael_keyexpansion_ctrl: NK must be 4, 6 or 8");
  end

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  // ---------------------------------------------------------------------------
  // GF(2^8) helpers; S-box computed as x^254 followed by the affine transform.
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    // x^254 = x^2 * x^4 * ... * x^128, which is the inverse (and maps 0 to 0)
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
           {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e      state_q, state_d;
  logic [3:0]  count_q, count_d;
  logic [3:0]  steps_q, steps_d;
  logic [7:0]  rc_q, rc_d;
  logic [3:0]  rk_idx_q, rk_idx_d;
  logic [31:0] buf_q [CAP];
  logic [31:0] buf_d [CAP];
  logic [31:0] ks_q [NK];
  logic [31:0] ks_d [NK];

  // ---------------------------------------------------------------------------
  // Key schedule step: next NK words from the current NK words and rc.
  // ---------------------------------------------------------------------------
  logic [31:0] nks [NK];

  always_comb begin
    nks[0] = ks_q[0] ^ sub_word({ks_q[NK-1][23:0], ks_q[NK-1][31:24]}) ^ {rc_q, 24'h0};
    for (int i = 1; i < NK; i++) begin
      // 256-bit keys apply an extra SubWord halfway through the step
      if (NK == 8 && i == 4) nks[i] = ks_q[i] ^ sub_word(nks[i-1]);
      else                   nks[i] = ks_q[i] ^ nks[i-1];
    end
  end

  // ---------------------------------------------------------------------------
  // Control and word FIFO
  // ---------------------------------------------------------------------------
  logic       pop;
  logic       step;
  logic [3:0] cnt_pop;

  assign rk_o      = {buf_q[3], buf_q[2], buf_q[1], buf_q[0]};
  assign rk_idx_o  = rk_idx_q;
  assign rk_last_o = (rk_idx_q == 4'(NR));

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    steps_d  = steps_q;
    rc_d     = rc_q;
    rk_idx_d = rk_idx_q;
    buf_d    = buf_q;
    ks_d     = ks_q;

    key_ready_o = (state_q == StIdle);
    rk_valid_o  = (state_q == StRun) && (count_q >= 4'd4);
    pop         = rk_valid_o && rk_ready_i;
    cnt_pop     = pop ? (count_q - 4'd4) : count_q;
    // Capacity is judged after this cycle's pop, so step depends on rk_ready_i
    step        = (state_q == StRun) && (int'(steps_q) < int'(NSTEPS)) &&
                  (int'(cnt_pop) + int'(NK) <= int'(CAP));

    unique case (state_q)
      StIdle: begin
        if (key_valid_i) begin
          for (int i = 0; i < CAP; i++) buf_d[i] = '0;
          for (int i = 0; i < NK; i++) begin
            ks_d[i]  = key_i[32*i +: 32];
            buf_d[i] = key_i[32*i +: 32];
          end
          count_d  = 4'(NK);
          steps_d  = '0;
          rc_d     = 8'h01;
          rk_idx_d = '0;
          state_d  = StRun;
        end
      end
      StRun: begin
        if (pop) begin
          for (int i = 0; i < CAP - 4; i++) buf_d[i] = buf_q[i+4];
          for (int i = CAP - 4; i < CAP; i++) buf_d[i] = '0;
          count_d  = cnt_pop;
          rk_idx_d = rk_idx_q + 4'd1;
        end
        if (step) begin
          // Append behind the words that remain after the pop
          for (int i = 0; i < CAP; i++) begin
            for (int j = 0; j < NK; j++) begin
              if (int'(cnt_pop) + j == i) buf_d[i] = nks[j];
            end
          end
          count_d = cnt_pop + 4'(NK);
          ks_d    = nks;
          steps_d = steps_q + 4'd1;
          rc_d    = xtime(rc_q);
        end
        if (pop && rk_last_o) begin
          // Surplus words from the final step are dropped here
          state_d  = StIdle;
          count_d  = '0;
          rk_idx_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      count_q  <= '0;
      steps_q  <= '0;
      rc_q     <= 8'h01;
      rk_idx_q <= '0;
      for (int i = 0; i < CAP; i++) buf_q[i] <= '0;
      for (int i = 0; i < NK; i++) ks_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      steps_q  <= steps_d;
      rc_q     <= rc_d;
      rk_idx_q <= rk_idx_d;
      buf_q    <= buf_d;
      ks_q     <= ks_d;
    end
  end

endmodule

// File: tb/tb_rijndael_keyexpansion_ctrl.sv
// Directed bench for rijndael_keyexpansion_ctrl: one instance each for NK = 4, 6, 8.
module tb_rijndael_keyexpansion_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [255:0] key_in    [3];
  logic         key_valid [3];
  logic         key_ready [3];
  logic [127:0] rk        [3];
  logic [3:0]   rk_idx    [3];
  logic         rk_last   [3];
  logic         rk_valid  [3];
  logic         rk_ready  [3];

  rijndael_keyexpansion_ctrl #(.NK(4)) u_nk4 (
    .clk_i(clk), .rst_ni(rst_n), .key_i(key_in[0][127:0]), .key_valid_i(key_valid[0]),
    .key_ready_o(key_ready[0]), .rk_o(rk[0]), .rk_idx_o(rk_idx[0]), .rk_last_o(rk_last[0]),
    .rk_valid_o(rk_valid[0]), .rk_ready_i(rk_ready[0])
  );
  rijndael_keyexpansion_ctrl #(.NK(6)) u_nk6 (
    .clk_i(clk), .rst_ni(rst_n), .key_i(key_in[1][191:0]), .key_valid_i(key_valid[1]),
    .key_ready_o(key_ready[1]), .rk_o(rk[1]), .rk_idx_o(rk_idx[1]), .rk_last_o(rk_last[1]),
    .rk_valid_o(rk_valid[1]), .rk_ready_i(rk_ready[1])
  );
  rijndael_keyexpansion_ctrl #(.NK(8)) u_nk8 (
    .clk_i(clk), .rst_ni(rst_n), .key_i(key_in[2]), .key_valid_i(key_valid[2]),
    .key_ready_o(key_ready[2]), .rk_o(rk[2]), .rk_idx_o(rk_idx[2]), .rk_last_o(rk_last[2]),
    .rk_valid_o(rk_valid[2]), .rk_ready_i(rk_ready[2])
  );

  int checks = 0;
  int errors = 0;

  logic [31:0]  exp_w [60];
  logic [127:0] got   [15];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference key expansion in the textbook word-by-word form
  function automatic logic [7:0] m_xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = m_xt(x);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] m_sbox(input logic [7:0] x);
    logic [7:0] inv = 8'h00;
    logic [7:0] s;
    for (int y = 1; y < 256; y++) begin
      if (m_mul(x, 8'(y)) == 8'h01) inv = 8'(y);
    end
    s = 8'h63;
    for (int k = 0; k < 5; k++) s = s ^ ((inv << k) | (inv >> (8 - k)));
    return s;
  endfunction

  function automatic logic [31:0] m_subw(input logic [31:0] w);
    return {m_sbox(w[31:24]), m_sbox(w[23:16]), m_sbox(w[15:8]), m_sbox(w[7:0])};
  endfunction

  task automatic compute_model(input int nk, input logic [255:0] key);
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < nk; i++) exp_w[i] = key[32*i +: 32];
    for (int i = nk; i < 4 * (nk + 7); i++) begin
      t = exp_w[i-1];
      if (i % nk == 0) begin
        t  = m_subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = m_xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = m_subw(t);
      end
      exp_w[i] = exp_w[i-nk] ^ t;
    end
  endtask

  function automatic logic [127:0] exp_rk(input int r);
    return {exp_w[4*r+3], exp_w[4*r+2], exp_w[4*r+1], exp_w[4*r]};
  endfunction

  // Called at a negedge while idle; returns at the negedge of cycle 1 after acceptance
  task automatic load(input int d, input logic [255:0] key);
    int w = 0;
    key_in[d]    = key;
    key_valid[d] = 1'b1;
    while (!key_ready[d] && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("key_ready_idle", 128'(key_ready[d]), 128'd1);
    @(negedge clk);
    key_valid[d] = 1'b0;
  endtask

  // Collects all round keys; returns at the negedge after the last pop
  task automatic drain(input int d, input int nk, input bit bp, output int cycles);
    int           n = 0;
    int           nr = nk + 6;
    bit           stalled = 1'b0;
    bit           done = 1'b0;
    bit           rdy;
    logic [127:0] hold_rk = '0;
    logic [3:0]   hold_idx = '0;
    cycles = 0;
    while (!done && cycles < 400) begin
      cycles++;
      rdy = bp ? ($urandom_range(0, 9) >= 3) : 1'b1;
      rk_ready[d] = rdy;
      chk("key_ready_low_in_run", 128'(key_ready[d]), 128'd0);
      if (rk_valid[d]) begin
        if (stalled) begin
          chk("hold_rk", rk[d], hold_rk);
          chk("hold_idx", 128'(rk_idx[d]), 128'(hold_idx));
        end
        chk("rk_idx", 128'(rk_idx[d]), 128'(n));
        chk("rk_last", 128'(rk_last[d]), 128'(n == nr));
        chk("rk_value", rk[d], exp_rk(n));
        if (rdy) begin
          got[n]  = rk[d];
          n++;
          done    = (n == nr + 1);
          stalled = 1'b0;
        end else begin
          stalled  = 1'b1;
          hold_rk  = rk[d];
          hold_idx = rk_idx[d];
        end
      end else if (!bp) begin
        chk("valid_every_cycle", 128'(rk_valid[d]), 128'd1);
      end
      @(negedge clk);
    end
    rk_ready[d] = 1'b0;
    if (!done) chk("drain_timeout_pops", 128'(n), 128'(nr + 1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] k4;
    logic [255:0] k6;
    logic [255:0] k8;
    logic [255:0] kb;
    int           cyc;
    int           w;

    k4 = 256'h09cf4f3c_abf71588_28aed2a6_2b7e1516;
    k6 = 256'h522c6b7b_62f8ead2_809079e5_c810f32b_da0e6452_8e73b0f7;
    k8 = 256'h0914dff4_2d9810a3_3b6108d7_1f352c07_857d7781_2b73aef0_15ca71be_603deb10;
    kb = 256'h0c0d0e0f_08090a0b_04050607_00010203;

    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      key_in[d]    = '0;
      key_valid[d] = 1'b0;
      rk_ready[d]  = 1'b0;
    end
    #12;
    chk("rst_key_ready", 128'(key_ready[0]), 128'd1);
    chk("rst_rk_valid", 128'(rk_valid[0]), 128'd0);
    chk("rst_rk", rk[0], 128'd0);
    chk("rst_rk_idx", 128'(rk_idx[0]), 128'd0);
    chk("rst_rk_last", 128'(rk_last[0]), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // NK=4, ready high
    compute_model(4, k4);
    load(0, k4);
    drain(0, 4, 1'b0, cyc);
    chk("nk4_pop_cycles", 128'(cyc), 128'd11);
    chk("nk4_ready_after", 128'(key_ready[0]), 128'd1);
    chk("nk4_rk0", got[0], k4[127:0]);
    chk("nk4_rk1", got[1], 128'h2a6c7605_23a33939_88542cb1_a0fafe17);
    chk("nk4_rk10", got[10], 128'hb6630ca6_e13f0cc8_c9ee2589_d014f9a8);

    // NK=6, ready high
    compute_model(6, k6);
    load(1, k6);
    drain(1, 6, 1'b0, cyc);
    chk("nk6_pop_cycles", 128'(cyc), 128'd13);
    chk("nk6_ready_after", 128'(key_ready[1]), 128'd1);
    chk("nk6_rk12", got[12], 128'h01002202_8ecc7204_448c773c_e98ba06f);

    // NK=8, ready high
    compute_model(8, k8);
    load(2, k8);
    drain(2, 8, 1'b0, cyc);
    chk("nk8_pop_cycles", 128'(cyc), 128'd15);
    chk("nk8_ready_after", 128'(key_ready[2]), 128'd1);
    chk("nk8_rk14", got[14], 128'h706c631e_046df344_e6188d0b_fe4890d1);

    // NK=8, random backpressure
    load(2, k8);
    drain(2, 8, 1'b1, cyc);
    chk("nk8bp_rk14", got[14], 128'h706c631e_046df344_e6188d0b_fe4890d1);
    chk("nk8bp_ready_after", 128'(key_ready[2]), 128'd1);

    // Asynchronous reset mid-expansion at rk_idx 5
    compute_model(4, k4);
    load(0, k4);
    rk_ready[0] = 1'b1;
    w = 0;
    while (rk_idx[0] != 4'd5 && w < 30) begin
      @(negedge clk);
      w++;
    end
    chk("mid_idx_reached", 128'(rk_idx[0]), 128'd5);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_key_ready", 128'(key_ready[0]), 128'd1);
    chk("arst_rk_valid", 128'(rk_valid[0]), 128'd0);
    chk("arst_rk", rk[0], 128'd0);
    chk("arst_rk_idx", 128'(rk_idx[0]), 128'd0);
    chk("arst_rk_last", 128'(rk_last[0]), 128'd0);
    rk_ready[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    load(0, k4);
    drain(0, 4, 1'b0, cyc);
    chk("post_rst_rk0", got[0], k4[127:0]);
    chk("post_rst_rk10", got[10], 128'hb6630ca6_e13f0cc8_c9ee2589_d014f9a8);

    // key_valid held across completion: second key taken in the first idle cycle
    compute_model(4, k4);
    rk_ready[0]  = 1'b1;
    key_in[0]    = k4;
    key_valid[0] = 1'b1;
    @(negedge clk);
    key_in[0] = kb;
    drain(0, 4, 1'b0, cyc);
    chk("b2b_first_cycles", 128'(cyc), 128'd11);
    chk("b2b_ready_idle", 128'(key_ready[0]), 128'd1);
    @(negedge clk);
    key_valid[0] = 1'b0;
    chk("b2b_second_valid", 128'(rk_valid[0]), 128'd1);
    chk("b2b_second_idx", 128'(rk_idx[0]), 128'd0);
    compute_model(4, kb);
    drain(0, 4, 1'b0, cyc);
    chk("b2b_second_cycles", 128'(cyc), 128'd11);
    chk("b2b_rk0", got[0], kb[127:0]);
    chk("b2b_rk10", got[10], 128'h4d2b30c5_f307a78b_e3944a17_13111d7f);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
